dcm_drp_rmw_master: RTL



---
 rtl/dcm_drp_rmw_master.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/dcm_drp_rmw_master.sv
// -----------------------------------------------------------------------------
// dcm_drp_rmw_master
//
// DRP initiator for a DCM_ADV-style clock manager. Accepts one register request
// at a time (read-only or masked read-modify-write), runs the DEN/DWE/DRDY
// handshake, holds the clock manager in reset around a write, waits for LOCKED
// to return and reports read data plus a status code.
//
// Ports:
//   DCLK, RST                      clock, asynchronous active-high reset
//   REQ_VALID/REQ_READY            request handshake
//   REQ_WR, REQ_ADDR,
//   REQ_MASK, REQ_DATA             request fields (mask bits select REQ_DATA)
//   RSP_VALID, RSP_DATA, RSP_ERR   completion pulse, data, status
//                                  (00 ok, 01 DRDY timeout, 10 LOCKED timeout)
//   DADDR, DI, DEN, DWE            DRP outputs
//   DO, DRDY                       DRP inputs
//   DCM_RST                        reset to the clock manager
//   LOCKED                         asynchronous lock indication
// -----------------------------------------------------------------------------
module dcm_drp_rmw_master #(
    parameter int unsigned DRDY_TIMEOUT = 64,
    parameter int unsigned RST_HOLD     = 3,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic        DCLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WR,
    input  logic [6:0]  REQ_ADDR,
    input  logic [15:0] REQ_MASK,
    input  logic [15:0] REQ_DATA,
    output logic        RSP_VALID,
    output logic [15:0] RSP_DATA,
    output logic [1:0]  RSP_ERR,
    output logic [6:0]  DADDR,
    output logic [15:0] DI,
    output logic        DEN,
    output logic        DWE,
    input  logic [15:0] DO,
    input  logic        DRDY,
    output logic        DCM_RST,
    input  logic        LOCKED
);

    localparam int unsigned MAX_T_A = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int unsigned MAX_T   = (MAX_T_A > RST_HOLD) ? MAX_T_A : RST_HOLD;
    localparam int unsigned CW      = $clog2(MAX_T + 1);

    // Counter is cleared on entry to each waiting state, so "last" is the
    // value seen in the final permitted cycle of that state.
    localparam logic [CW-1:0] C_DRDY_LAST = CW'(DRDY_TIMEOUT - 1);
    localparam logic [CW-1:0] C_HOLD_LAST = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] C_LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR_ISSUE,
        S_WR_WAIT,
        S_RST_HOLD,
        S_LOCK_WAIT,
        S_DONE
    } state_t;

    state_t        r_state;
    logic          r_wr;
    logic [15:0]   r_mask;
    logic [15:0]   r_data;
    logic [15:0]   r_rdata;
    logic [CW-1:0] r_cnt;
    logic          r_lock_s1;
    logic          r_lock_s2;
    logic [CW-1:0] w_cnt_inc;

    // Saturating increment: the counter never wraps back to zero.
    always_comb begin
        w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    end

    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_wr      <= 1'b0;
            r_mask    <= '0;
            r_data    <= '0;
            r_rdata   <= '0;
            r_cnt     <= '0;
            r_lock_s1 <= 1'b0;
            r_lock_s2 <= 1'b0;
            REQ_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= '0;
            RSP_ERR   <= 2'b00;
            DADDR     <= '0;
            DI        <= '0;
            DEN       <= 1'b0;
            DWE       <= 1'b0;
            DCM_RST   <= 1'b0;
        end else begin
            r_lock_s1 <= LOCKED;
            r_lock_s2 <= r_lock_s1;
            DEN       <= 1'b0;
            DWE       <= 1'b0;
            RSP_VALID <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    REQ_READY <= 1'b1;
                    if (REQ_VALID && REQ_READY) begin
                        REQ_READY <= 1'b0;
                        r_wr      <= REQ_WR;
                        r_mask    <= REQ_MASK;
                        r_data    <= REQ_DATA;
                        DADDR     <= REQ_ADDR;
                        DEN       <= 1'b1;
                        r_state   <= S_RD_ISSUE;
                    end
                end

                S_RD_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    if (DRDY) begin
                        r_rdata <= DO;
                        if (r_wr) begin
                            // Write strobe launched straight from the read
                            // completion so DEN lands one cycle after DRDY.
                            DI      <= (DO & ~r_mask) | (r_data & r_mask);
                            DEN     <= 1'b1;
                            DWE     <= 1'b1;
                            DCM_RST <= 1'b1;
                            r_state <= S_WR_ISSUE;
                        end else begin
                            RSP_VALID <= 1'b1;
                            RSP_DATA  <= DO;
                            RSP_ERR   <= 2'b00;
                            r_state   <= S_DONE;
                        end
                    end else if (r_cnt == C_DRDY_LAST) begin
                        RSP_VALID <= 1'b1;
                        RSP_DATA  <= '0;
                        RSP_ERR   <= 2'b01;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_WR_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WR_WAIT;
                end

                S_WR_WAIT: begin
                    if (DRDY) begin
                        r_cnt   <= '0;
                        r_state <= S_RST_HOLD;
                    end else if (r_cnt == C_DRDY_LAST) begin
                        DCM_RST   <= 1'b0;
                        RSP_VALID <= 1'b1;
                        RSP_DATA  <= r_rdata;
                        RSP_ERR   <= 2'b01;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_RST_HOLD: begin
                    if (r_cnt == C_HOLD_LAST) begin
                        DCM_RST <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_LOCK_WAIT;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_LOCK_WAIT: begin
                    // DI still holds the value that was written.
                    if (r_lock_s2) begin
                        RSP_VALID <= 1'b1;
                        RSP_DATA  <= DI;
                        RSP_ERR   <= 2'b00;
                        r_state   <= S_DONE;
                    end else if (r_cnt == C_LOCK_LAST) begin
                        RSP_VALID <= 1'b1;
                        RSP_DATA  <= DI;
                        RSP_ERR   <= 2'b10;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_DONE: begin
                    REQ_READY <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
